// File: rtl/cpu_pkg.sv
// +----------------------------------------------------------------------------+
// | cpu_pkg : opcode constants, instruction field positions, width defaults     |
// | Rev 1.0 : initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_ADDR_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  function automatic logic writes_reg(input logic [5:0] op);
    logic w;
    case (op)
      OP_RTYPE, OP_ADDI, OP_ORI, OP_LW: w = 1'b1;
      default:                          w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// +----------------------------------------------------------------------------+
// | reg_scoreboard : pending-write vector with set/clear and three lookups      |
// | Rev 1.0 : initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module reg_scoreboard #(
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_set_en,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic              i_clr_en,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic [ADDR_W-1:0] i_addr_a,
  input  logic [ADDR_W-1:0] i_addr_b,
  input  logic [ADDR_W-1:0] i_addr_c,
  output logic              o_hit_a,
  output logic              o_hit_b,
  output logic              o_hit_c
);

  localparam logic [NREGS-1:0] c_one = NREGS'(1);

  logic [NREGS-1:0] r_pending;
  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_pend_eff;

  assign w_clr      = i_clr_en ? (c_one << i_clr_addr) : '0;
  assign w_set      = i_set_en ? (c_one << i_set_addr) : '0;
  // Lookups see this cycle's writeback already retired.
  assign w_pend_eff = r_pending & ~w_clr;

  assign o_hit_a = w_pend_eff[i_addr_a];
  assign o_hit_b = w_pend_eff[i_addr_b];
  assign o_hit_c = w_pend_eff[i_addr_c];

  // Set is OR-ed after the clear so it wins; bit 0 is forced clear.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= ((r_pending & ~w_clr) | w_set) & ~c_one;
    end
  end

endmodule

`default_nettype wire

// File: rtl/operand_fetch_stage.sv
// +----------------------------------------------------------------------------+
// | operand_fetch_stage : decode, hazard stall, WB bypass, registered output    |
// | Rev 1.0 : initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module operand_fetch_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W  = CPU_DATA_W,
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int NREGS   = 32,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  output logic [ADDR_W-1:0]  RD1,
  output logic [ADDR_W-1:0]  RD2,
  input  logic [DATA_W-1:0]  readData1,
  input  logic [DATA_W-1:0]  readData2,
  input  logic               wb_valid,
  input  logic [ADDR_W-1:0]  wb_reg,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_op1,
  output logic [DATA_W-1:0]  out_op2,
  output logic [DATA_W-1:0]  out_imm,
  output logic [ADDR_W-1:0]  out_dest,
  output logic               out_regwrite,
  output logic [STALL_W-1:0] stall_count
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]         r_state;
  logic [DATA_W-1:0]  r_op1;
  logic [DATA_W-1:0]  r_op2;
  logic [DATA_W-1:0]  r_imm;
  logic [ADDR_W-1:0]  r_dest;
  logic               r_regwrite;
  logic [STALL_W-1:0] r_stall;

  logic [5:0]         w_op;
  logic [ADDR_W-1:0]  w_rs;
  logic [ADDR_W-1:0]  w_rt;
  logic [ADDR_W-1:0]  w_rd;
  logic [15:0]        w_imm16;
  logic [ADDR_W-1:0]  w_dest;
  logic               w_writes;
  logic               w_hit_rs;
  logic               w_hit_rt;
  logic               w_hit_dest;
  logic               w_hazard;
  logic               w_fire;
  logic [DATA_W-1:0]  w_op1;
  logic [DATA_W-1:0]  w_op2;

  assign w_op    = in_instr[OP_HI:OP_LO];
  assign w_rs    = ADDR_W'(in_instr[RS_HI:RS_LO]);
  assign w_rt    = ADDR_W'(in_instr[RT_HI:RT_LO]);
  assign w_rd    = ADDR_W'(in_instr[RD_HI:RD_LO]);
  assign w_imm16 = in_instr[IMM_HI:IMM_LO];

  assign RD1 = w_rs;
  assign RD2 = w_rt;

  assign w_dest   = (w_op == OP_RTYPE) ? w_rd : w_rt;
  assign w_writes = writes_reg(w_op) && (w_dest != '0);

  reg_scoreboard #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .i_rst_n    (reset),
    .i_set_en   (w_fire & w_writes),
    .i_set_addr (w_dest),
    .i_clr_en   (wb_valid),
    .i_clr_addr (wb_reg),
    .i_addr_a   (w_rs),
    .i_addr_b   (w_rt),
    .i_addr_c   (w_dest),
    .o_hit_a    (w_hit_rs),
    .o_hit_b    (w_hit_rt),
    .o_hit_c    (w_hit_dest)
  );

  assign w_hazard = w_hit_rs | w_hit_rt | (w_writes & w_hit_dest);
  assign in_ready = reset & ~w_hazard & (~out_valid | out_ready);
  assign w_fire   = in_valid & in_ready;

  // Same-cycle writeback forwarding; r0 always reads from the regfile.
  assign w_op1 = (wb_valid && (wb_reg == w_rs) && (w_rs != '0)) ? wb_data : readData1;
  assign w_op2 = (wb_valid && (wb_reg == w_rt) && (w_rt != '0)) ? wb_data : readData2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_EMPTY;
      r_op1      <= '0;
      r_op2      <= '0;
      r_imm      <= '0;
      r_dest     <= '0;
      r_regwrite <= 1'b0;
    end else if (w_fire) begin
      r_state    <= S_FULL;
      r_op1      <= w_op1;
      r_op2      <= w_op2;
      r_imm      <= {{(DATA_W-16){w_imm16[15]}}, w_imm16};
      r_dest     <= w_dest;
      r_regwrite <= w_writes;
    end else if (out_ready) begin
      r_state    <= S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall <= '0;
    end else if (in_valid && !in_ready && !(&r_stall)) begin
      r_stall <= r_stall + STALL_W'(1);
    end
  end

  assign out_valid    = (r_state == S_FULL);
  assign out_op1      = r_op1;
  assign out_op2      = r_op2;
  assign out_imm      = r_imm;
  assign out_dest     = r_dest;
  assign out_regwrite = r_regwrite;
  assign stall_count  = r_stall;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch_stage.sv
// +----------------------------------------------------------------------------+
// | tb_operand_fetch_stage : directed self-checking bench for operand fetch     |
// | Rev 1.0 : initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_operand_fetch_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [4:0]  RD1;
  logic [4:0]  RD2;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [31:0] out_imm;
  logic [4:0]  out_dest;
  logic        out_regwrite;
  logic [15:0] stall_count;

  int n_pass;
  int n_total;

  operand_fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .RD1          (RD1),
    .RD2          (RD2),
    .readData1    (readData1),
    .readData2    (readData2),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_op1      (out_op1),
    .out_op2      (out_op2),
    .out_imm      (out_imm),
    .out_dest     (out_dest),
    .out_regwrite (out_regwrite),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 11'h000};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    in_valid = 1'b1;
    in_instr = enc_i(6'h08, 5'd1, 5'd5, 16'h8000);
    tick();
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%0b exp=0", in_ready); else n_pass++;
    n_total++; if (stall_count !== 16'd0) $display("FAIL reset_stall got=%0d exp=0", stall_count); else n_pass++;
    n_total++; if (out_op1 !== 32'd0) $display("FAIL reset_op1 got=%h exp=0", out_op1); else n_pass++;
    reset    = 1'b1;
    in_valid = 1'b0;
    settle();
    n_total++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got=%0b exp=1", in_ready); else n_pass++;
  endtask

  task automatic test_basic_issue();
    in_instr  = enc_i(6'h08, 5'd1, 5'd5, 16'h8000);
    readData1 = 32'd7;
    readData2 = 32'd99;
    in_valid  = 1'b1;
    settle();
    n_total++; if (RD1 !== 5'd1) $display("FAIL basic_rd1 got=%0d exp=1", RD1); else n_pass++;
    n_total++; if (RD2 !== 5'd5) $display("FAIL basic_rd2 got=%0d exp=5", RD2); else n_pass++;
    tick();
    in_valid = 1'b0;
    n_total++; if (out_valid !== 1'b1) $display("FAIL basic_valid got=%0b exp=1", out_valid); else n_pass++;
    n_total++; if (out_op1 !== 32'd7) $display("FAIL basic_op1 got=%h exp=7", out_op1); else n_pass++;
    n_total++; if (out_imm !== 32'hFFFF8000) $display("FAIL basic_imm got=%h exp=ffff8000", out_imm); else n_pass++;
    n_total++; if (out_dest !== 5'd5) $display("FAIL basic_dest got=%0d exp=5", out_dest); else n_pass++;
    n_total++; if (out_regwrite !== 1'b1) $display("FAIL basic_regwrite got=%0b exp=1", out_regwrite); else n_pass++;
  endtask

  task automatic test_raw_stall();
    in_instr = enc_r(5'd5, 5'd2, 5'd6);
    in_valid = 1'b1;
    settle();
    n_total++; if (in_ready !== 1'b0) $display("FAIL raw_stall_ready got=%0b exp=0", in_ready); else n_pass++;
    tick();
    n_total++; if (stall_count !== 16'd1) $display("FAIL raw_stall_count got=%0d exp=1", stall_count); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL raw_drained got=%0b exp=0", out_valid); else n_pass++;
    wb_valid  = 1'b1;
    wb_reg    = 5'd5;
    wb_data   = 32'h1234;
    readData1 = 32'hDEAD;
    settle();
    n_total++; if (in_ready !== 1'b1) $display("FAIL raw_wb_ready got=%0b exp=1", in_ready); else n_pass++;
    tick();
    wb_valid = 1'b0;
    in_valid = 1'b0;
    n_total++; if (out_op1 !== 32'h1234) $display("FAIL raw_bypass_op1 got=%h exp=1234", out_op1); else n_pass++;
    n_total++; if (out_dest !== 5'd6) $display("FAIL raw_dest got=%0d exp=6", out_dest); else n_pass++;
    n_total++; if (stall_count !== 16'd1) $display("FAIL raw_stall_hold got=%0d exp=1", stall_count); else n_pass++;
    wb_valid = 1'b1;
    wb_reg   = 5'd6;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_instr  = enc_i(6'h0D, 5'd3, 5'd8, 16'h00F0);
    readData1 = 32'h11;
    in_valid  = 1'b1;
    tick();
    in_instr  = enc_i(6'h0D, 5'd4, 5'd9, 16'h0001);
    readData1 = 32'h22;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_total++; if (in_ready !== 1'b0) $display("FAIL bp_ready[%0d] got=%0b exp=0", i, in_ready); else n_pass++;
      tick();
      n_total++;
      if (out_op1 !== 32'h11 || out_dest !== 5'd8 || out_imm !== 32'hF0 || out_valid !== 1'b1)
        $display("FAIL bp_hold[%0d] got op1=%h dest=%0d imm=%h v=%0b exp op1=11 dest=8 imm=f0 v=1",
                 i, out_op1, out_dest, out_imm, out_valid);
      else n_pass++;
    end
    n_total++; if (stall_count !== 16'd4) $display("FAIL bp_stall got=%0d exp=4", stall_count); else n_pass++;
    out_ready = 1'b1;
    settle();
    n_total++; if (in_ready !== 1'b1) $display("FAIL bp_b2b_ready got=%0b exp=1", in_ready); else n_pass++;
    tick();
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b1 || out_op1 !== 32'h22 || out_dest !== 5'd9)
      $display("FAIL bp_b2b got v=%0b op1=%h dest=%0d exp v=1 op1=22 dest=9", out_valid, out_op1, out_dest);
    else n_pass++;
    wb_valid = 1'b1;
    wb_reg   = 5'd8;
    tick();
    wb_reg   = 5'd9;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic test_r0_store();
    in_instr  = enc_r(5'd1, 5'd2, 5'd0);
    in_valid  = 1'b1;
    tick();
    n_total++; if (out_regwrite !== 1'b0) $display("FAIL r0_regwrite got=%0b exp=0", out_regwrite); else n_pass++;
    n_total++; if (out_dest !== 5'd0) $display("FAIL r0_dest got=%0d exp=0", out_dest); else n_pass++;
    in_instr = enc_i(6'h2B, 5'd1, 5'd3, 16'h0004);
    tick();
    n_total++; if (out_regwrite !== 1'b0) $display("FAIL sw_regwrite got=%0b exp=0", out_regwrite); else n_pass++;
    n_total++; if (out_dest !== 5'd3) $display("FAIL sw_dest got=%0d exp=3", out_dest); else n_pass++;
    in_instr  = enc_r(5'd3, 5'd0, 5'd10);
    readData2 = 32'd0;
    wb_valid  = 1'b1;
    wb_reg    = 5'd0;
    wb_data   = 32'hBAD;
    settle();
    n_total++; if (in_ready !== 1'b1) $display("FAIL sw_no_stall got=%0b exp=1", in_ready); else n_pass++;
    tick();
    in_valid = 1'b0;
    n_total++; if (out_op2 !== 32'd0) $display("FAIL r0_no_bypass got=%h exp=0", out_op2); else n_pass++;
    wb_reg = 5'd10;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic test_same_edge();
    in_instr = enc_i(6'h08, 5'd1, 5'd7, 16'h0001);
    in_valid = 1'b1;
    tick();
    in_instr  = enc_i(6'h08, 5'd2, 5'd7, 16'h0002);
    readData2 = 32'h55;
    wb_valid  = 1'b1;
    wb_reg    = 5'd7;
    wb_data   = 32'h77;
    settle();
    n_total++; if (in_ready !== 1'b1) $display("FAIL se_ready got=%0b exp=1", in_ready); else n_pass++;
    tick();
    wb_valid = 1'b0;
    n_total++; if (out_op2 !== 32'h77) $display("FAIL se_bypass_op2 got=%h exp=77", out_op2); else n_pass++;
    in_instr = enc_r(5'd7, 5'd0, 5'd11);
    settle();
    n_total++; if (in_ready !== 1'b0) $display("FAIL se_pending7 got=%0b exp=0", in_ready); else n_pass++;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL mid_reset_valid got=%0b exp=0", out_valid); else n_pass++;
    n_total++; if (out_dest !== 5'd0) $display("FAIL mid_reset_dest got=%0d exp=0", out_dest); else n_pass++;
    n_total++; if (stall_count !== 16'd0) $display("FAIL mid_reset_stall got=%0d exp=0", stall_count); else n_pass++;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    settle();
    n_total++; if (in_ready !== 1'b1) $display("FAIL mid_reset_pending got=%0b exp=1", in_ready); else n_pass++;
    in_valid = 1'b0;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    readData1 = 32'd0;
    readData2 = 32'd0;
    wb_valid  = 1'b0;
    wb_reg    = 5'd0;
    wb_data   = 32'd0;
    out_ready = 1'b1;
    test_reset();
    test_basic_issue();
    test_raw_stall();
    test_backpressure();
    test_r0_store();
    test_same_edge();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
